// File: rtl/uart_rx_ctrl.sv
// Serial receive controller: synchronizes the line, times each bit with a
// mid-bit sample strobe, shifts data in LSB first and reports ready/error status.
module uart_rx_ctrl #(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 serial_in,
  input  logic                 data_read,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_ready,
  output logic                 framing_error,
  output logic                 overrun_error
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_H    = CW'(CLKS_PER_BIT / 2);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START_CHK, RECV, STOP_CHK, LOAD, WAIT_IDLE} state_e;

  state_e                state_q, state_d;
  logic                  sync1_q, sync2_q, edge_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_BITS-1:0]  sh_q, sh_d, rx_q, rx_d;
  logic                  rdy_q, rdy_d, fe_q, fe_d, ov_q, ov_d;
  logic                  start_edge, strobe, line;

  assign line       = sync2_q;
  assign start_edge = !sync2_q && edge_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      edge_q  <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      rx_q    <= '0;
      rdy_q   <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      sync1_q <= serial_in;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      rx_q    <= rx_d;
      rdy_q   <= rdy_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    rx_d    = rx_q;
    rdy_d   = rdy_q;
    fe_d    = fe_q;
    ov_d    = ov_q;
    strobe  = 1'b0;
    if (data_read) begin
      rdy_d = 1'b0;
      ov_d  = 1'b0;
    end
    // Counter runs 1..CLKS_PER_BIT; strobe fires on the edge it reaches H.
    if (state_q == START_CHK || state_q == RECV || state_q == STOP_CHK) begin
      cnt_d  = (cnt_q == CNT_MAX) ? CW'(1) : cnt_q + CW'(1);
      strobe = (cnt_d == CNT_H);
    end
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start_edge) state_d = START_CHK;
      end
      START_CHK: begin
        if (strobe) begin
          idx_d   = '0;
          state_d = line ? IDLE : RECV;
        end
      end
      RECV: begin
        if (strobe) begin
          sh_d  = {line, sh_q[DATA_BITS-1:1]};
          idx_d = idx_q + IW'(1);
          if (idx_q == IDX_LAST) state_d = STOP_CHK;
        end
      end
      STOP_CHK: begin
        if (strobe) begin
          if (line) begin
            state_d = LOAD;
          end else begin
            fe_d    = 1'b1;
            state_d = WAIT_IDLE;
          end
        end
      end
      LOAD: begin
        // A read landing on the load cycle acknowledges the old byte, not the new one.
        rx_d    = sh_q;
        rdy_d   = 1'b1;
        fe_d    = 1'b0;
        ov_d    = ov_q | (rdy_q & !data_read);
        state_d = IDLE;
      end
      WAIT_IDLE: begin
        if (line) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_data       = rx_q;
  assign data_ready    = rdy_q;
  assign framing_error = fe_q;
  assign overrun_error = ov_q;
endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Serial receive controller for the design's byte-oriented serial input. It synchronizes the raw line, detects a start bit, times each bit period with internal bit-period and bit-index counters, and samples at mid-bit. It shifts data in LSB first, checks the stop bit, and presents the completed byte with ready, framing-error and overrun-error status to the downstream register/bus block.

## Interface
- CLKS_PER_BIT, default 10: clk cycles per serial bit; legal range ≥ 4.
- DATA_BITS, default 8: data bits per frame; legal range 5–9.

- clk  input  1  system clock, rising edge.
- n_rst  input  1  reset, asynchronous, active-low.
- serial_in  input  1  raw asynchronous serial line; idle high.
- data_read  input  1  one-cycle pulse from the consumer acknowledging rx_data.
- rx_data  output  DATA_BITS  last good received byte, LSB = first data bit on the line.
- data_ready  output  1  rx_data holds an unread byte.
- framing_error  output  1  last frame had stop bit = 0.
- overrun_error  output  1  a byte was loaded while data_ready was already 1.

## Operation
- serial_in passes through a 2-flop synchronizer (reset value 1), then an edge register (reset value 1). The start edge is synchronized = 0 while the edge register = 1.
- Bit timer:
  - width $clog2(CLKS_PER_BIT+1).
  - Cleared on the start edge.
  - Counts 1..CLKS_PER_BIT, then wraps to 1.
  - Sample strobe at count H = CLKS_PER_BIT/2 (floor) for the start bit, then every CLKS_PER_BIT cycles after that.
- Bit index counter:
  - width $clog2(DATA_BITS+1).
  - Cleared when entering RECV.
  - Increments per data sample.
  - Terminal at DATA_BITS.
- FSM states:
  - IDLE: wait for the start edge, then go to START_CHK.
  - START_CHK: at the start sample, if the line is 1 it is a false start and the FSM goes to IDLE with no status change. If the line is 0, go to RECV.
  - RECV: each strobe shifts the sampled bit into the MSB of the shift register (right shift). After DATA_BITS samples, go to STOP_CHK.
  - STOP_CHK:
    - Stop sample = 1: go to LOAD.
    - Stop sample = 0: set framing_error = 1, leave rx_data and data_ready unchanged, go to WAIT_IDLE.
  - LOAD, one cycle:
    - rx_data ← shift register; data_ready ← 1; framing_error ← 0.
    - If data_ready was 1 and data_read is not asserted this cycle, overrun_error ← 1.
    - Go to IDLE.
  - WAIT_IDLE: stay until the synchronized line = 1, then go to IDLE. A new start edge can only be detected after this.
- data_read clears data_ready and overrun_error on the next edge, except in the LOAD cycle.
- LOAD and data_read in the same cycle: load wins, data_ready stays 1, overrun_error is not set.
- framing_error holds until the next successful LOAD or reset.
- Reset mid-frame: all state goes to its reset value immediately and the partial frame is discarded.

## Timing
- Reset values:
  - rx_data = 0
  - data_ready = 0
  - framing_error = 0
  - overrun_error = 0
  - FSM = IDLE
  - synchronizer and edge registers = 1
- Cycle 0 is the edge at which the start edge is detected, 2 cycles after serial_in falls.
- Sample times:
  - Start sample: cycle H.
  - Data bit k (k = 0..DATA_BITS-1): cycle H+(k+1)·CLKS_PER_BIT.
  - Stop sample: cycle H+(DATA_BITS+1)·CLKS_PER_BIT.
- data_ready, rx_data, or framing_error visible 1 cycle after the stop sample: cycle 96 for the defaults.
- Back-to-back frames: a start edge arriving at least 1 cycle after LOAD is detected.
- Line low shorter than H cycles at the detector is rejected as a false start.

## Test plan
- Defaults, send 0xA5 with stop = 1 → rx_data = 0xA5, data_ready rises at cycle 96, framing_error = 0; data_read pulse → data_ready = 0 on the next cycle.
- 3-cycle low glitch on serial_in → no data_ready, no error, FSM back in IDLE by cycle H+1; a following 0x3C frame is received correctly.
- Send 0x3C with stop = 0 → framing_error = 1, data_ready = 0, rx_data unchanged; hold the line low for 20 cycles, then send 0x81 → rx_data = 0x81, framing_error = 0.
- Send 0x11 then 0x22 with no data_read → rx_data = 0x22, data_ready = 1, overrun_error = 1; data_read → both cleared.
- data_read asserted exactly in the LOAD cycle of a second byte 0x77 → data_ready = 1, overrun_error = 0.
- n_rst pulsed during data bit 4 of 0xFF → all outputs 0 immediately; next frame 0x5A → rx_data = 0x5A.
